// File: rtl/mock_cpu_pkg.sv
// Shared types and helpers for the mock CPU FIFO traffic generator/checker.
// Holds the LFSR polynomial, datapath widths, FSM state type and result model.
package mock_cpu_pkg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;
    localparam logic [DATA_W-1:0] LFSR_MASK = 32'h8020_0003;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    // The CPU side returns lo16 + hi16 with the carry kept in bit 16.
    function automatic logic [DATA_W-1:0] expected_sum(input logic [DATA_W-1:0] word);
        logic [16:0] sum;
        sum = {1'b0, word[15:0]} + {1'b0, word[31:16]};
        return {15'b0, sum};
    endfunction

endpackage

// File: rtl/mock_cpu_lfsr.sv
// 32-bit right-shifting Galois LFSR with seed load; a zero seed is replaced by 1.
// Latency: state updates one cycle after load/advance.
// Backpressure: none; holds its value whenever advance is low.
module mock_cpu_lfsr
    import mock_cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] seed,
    input  logic              load,
    input  logic              advance,
    output logic [DATA_W-1:0] state
);

    logic [DATA_W-1:0] seed_nz;
    logic [DATA_W-1:0] nxt;

    assign seed_nz = (seed == '0) ? {{(DATA_W-1){1'b0}}, 1'b1} : seed;
    assign nxt     = {1'b0, state[DATA_W-1:1]} ^ (state[0] ? LFSR_MASK : '0);

    always_ff @(posedge clk) begin
        if (rst || load) begin
            state <= seed_nz;
        end else if (advance) begin
            state <= nxt;
        end
    end

endmodule

// File: rtl/mock_cpu_traffic.sv
// Uncore-side traffic generator/checker: writes LFSR words, checks returned lo+hi sums.
// Latency: winc/rinc are combinational from wfull/rempty; status updates the cycle after a read.
// Backpressure: writes stall on wfull, reads stall on rempty; a read-side watchdog aborts the run.
module mock_cpu_traffic
    import mock_cpu_pkg::*;
#(
    parameter int                NUM_WORDS = 64,
    parameter logic [DATA_W-1:0] SEED      = 32'h0000_0001,
    parameter int                TIMEOUT   = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [DATA_W-1:0] wdata,
    output logic              winc,
    input  logic              wfull,
    input  logic [DATA_W-1:0] rdata,
    output logic              rinc,
    input  logic              rempty,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  err_count,
    output logic [CNT_W-1:0]  first_err_idx
);

    localparam logic [CNT_W-1:0] NUM_W        = CNT_W'(NUM_WORDS);
    localparam logic [31:0]      TIMEOUT_LAST = 32'(TIMEOUT - 1);

    state_t            st;
    logic [CNT_W-1:0]  wr_cnt;
    logic [CNT_W-1:0]  rd_cnt;
    logic [31:0]       idle_cnt;
    logic [DATA_W-1:0] gen_q;
    logic [DATA_W-1:0] chk_q;
    logic              run;
    logic              load;
    logic              mismatch;
    logic [CNT_W-1:0]  err_next;

    assign run      = (st == ST_RUN);
    assign load     = start && !run;
    assign winc     = run && (wr_cnt < NUM_W) && !wfull;
    assign rinc     = run && (rd_cnt < NUM_W) && !rempty;
    assign wdata    = gen_q;
    assign mismatch = (rdata != expected_sum(chk_q));

    // Next error count, so completion can judge pass including the final compare.
    always_comb begin
        err_next = err_count;
        if (rinc && mismatch && (err_count != '1)) begin
            err_next = err_count + 1'b1;
        end
    end

    mock_cpu_lfsr u_gen (
        .clk     (clk),
        .rst     (rst),
        .seed    (SEED),
        .load    (load),
        .advance (winc),
        .state   (gen_q)
    );

    mock_cpu_lfsr u_chk (
        .clk     (clk),
        .rst     (rst),
        .seed    (SEED),
        .load    (load),
        .advance (rinc),
        .state   (chk_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            st            <= ST_IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= '0;
            first_err_idx <= '1;
            wr_cnt        <= '0;
            rd_cnt        <= '0;
            idle_cnt      <= '0;
        end else begin
            case (st)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        st            <= ST_RUN;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                        pass          <= 1'b0;
                        err_count     <= '0;
                        first_err_idx <= '1;
                        wr_cnt        <= '0;
                        rd_cnt        <= '0;
                        idle_cnt      <= '0;
                    end
                end
                ST_RUN: begin
                    if (winc) begin
                        wr_cnt <= wr_cnt + 1'b1;
                    end
                    err_count <= err_next;
                    if (rinc) begin
                        if (mismatch && (err_count == '0)) begin
                            first_err_idx <= rd_cnt;
                        end
                        rd_cnt   <= rd_cnt + 1'b1;
                        idle_cnt <= '0;
                        if (rd_cnt == NUM_W - 1'b1) begin
                            st   <= ST_DONE;
                            busy <= 1'b0;
                            done <= 1'b1;
                            pass <= (err_next == '0);
                        end
                    end else if (idle_cnt == TIMEOUT_LAST) begin
                        st   <= ST_DONE;
                        busy <= 1'b0;
                        done <= 1'b1;
                        pass <= 1'b0;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

endmodule
